dis_scan_ctrl: RTL and testbench

Sequencing controller for the 7-segment display path. It accepts a 16-bit value with a load strobe and converts it to five BCD digits using a sequential double-dabble, or to hex nibbles. It then time-multiplexes the digits onto a single nibble output with active-low digit enables and leading-zero blanking. It sits between the bus/register-file value sources and the segment decoder, replacing per-digit combinational decode with one scanned decoder.

---
 rtl/dis_pkg.sv | 24 ++
 rtl/bcd_dabble.sv | 48 ++++
 rtl/dis_scan_ctrl.sv | 102 ++++++++++
 tb/tb_dis_scan_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dis_pkg.sv
// Shared definitions for the scanned 7-segment display path.
// Holds the digit count, the conversion length, the FSM encoding and the blanking rule.
package dis_pkg;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_ITERS  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Digit k is blank when it and every more significant digit are zero.
  // Digit 0 is never blank.
  function automatic logic digit_blank(input logic [19:0] disp, input logic [2:0] k);
    logic b;
    b = (k != 3'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(k)) && (disp[4*i +: 4] != 4'd0)) b = 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits, one shift per cycle.
// done is high in the cycle whose edge performs the final shift; bcd then holds that final result.
module bcd_dabble
  import dis_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] bin;
  logic [19:0] acc;
  logic [19:0] corr;
  logic [3:0]  cnt;
  logic        run;

  always_comb begin
    corr = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) corr[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    bcd  = {corr[18:0], bin[15]};
    done = run && (cnt == 4'(BCD_ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      bin <= in;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= bcd;
      bin <= {bin[14:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/dis_scan_ctrl.sv
// Display sequencing controller: decimal or hex capture into a display register,
// then a continuously running digit scan with active-low enables and leading-zero blanking.
//
// state | meaning
// IDLE  | waiting for load; a hex load updates the display in place
// CONV  | decimal conversion running in bcd_dabble
module dis_scan_ctrl
  import dis_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        tog,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [2:0]  dig_sel,
  output logic [4:0]  enbar
);

  state_t      state, state_nxt;
  logic        start;
  logic        done;
  logic [19:0] bcd_res;
  logic [19:0] disp;
  logic [15:0] presc;
  logic        tc;

  bcd_dabble u_dabble (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .done  (done),
    .bcd   (bcd_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (load && !tog) begin
          start     = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The display is only ever written whole, so a conversion never shows partial digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
    end else if ((state == IDLE) && load && tog) begin
      disp <= {4'd0, in};
    end else if ((state == CONV) && done) begin
      disp <= bcd_res;
    end
  end

  assign tc = (presc == 16'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      dig_sel <= '0;
    end else if (tc) begin
      presc   <= '0;
      dig_sel <= (dig_sel == 3'd4) ? 3'd0 : dig_sel + 3'd1;
    end else begin
      presc   <= presc + 16'd1;
    end
  end

  always_comb begin
    digit = 4'd0;
    case (dig_sel)
      3'd0:    digit = disp[3:0];
      3'd1:    digit = disp[7:4];
      3'd2:    digit = disp[11:8];
      3'd3:    digit = disp[15:12];
      3'd4:    digit = disp[19:16];
      default: digit = 4'd0;
    endcase
    enbar = digit_blank(disp, dig_sel) ? 5'h1f : ~(5'd1 << dig_sel);
  end

  assign busy = (state == CONV);

endmodule

// File: tb/tb_dis_scan_ctrl.sv
// Directed bench for dis_scan_ctrl: reset, decimal/hex loads, dropped load and reset mid-conversion.
module tb_dis_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] in;
  logic        tog;
  logic        busy;
  logic [3:0]  digit;
  logic [2:0]  dig_sel;
  logic [4:0]  enbar;

  logic        busy1;
  logic [3:0]  digit1;
  logic [2:0]  dig_sel1;
  logic [4:0]  enbar1;

  int total = 0;
  int bad   = 0;

  dis_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .in(in), .tog(tog),
    .busy(busy), .digit(digit), .dig_sel(dig_sel), .enbar(enbar)
  );

  dis_scan_ctrl #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .load(1'b0), .in(16'd0), .tog(1'b0),
    .busy(busy1), .digit(digit1), .dig_sel(dig_sel1), .enbar(enbar1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  // Walk the scan once; expd holds the expected nibbles, blanks marks blanked indices.
  task automatic scan_chk(input string tag, input logic [19:0] expd, input logic [4:0] blanks);
    for (int k = 0; k < 5; k++) begin
      int guard;
      logic [4:0] en_exp;
      guard = 0;
      while ((int'(dig_sel) != k) && guard < 40) begin
        guard++;
        step();
      end
      chk({tag, "_reach"}, 32'(guard < 40), 32'd1);
      en_exp = blanks[k] ? 5'h1f : ~(5'd1 << k);
      chk($sformatf("%s_digit%0d", tag, k), 32'(digit), 32'(expd[4*k +: 4]));
      chk($sformatf("%s_enbar%0d", tag, k), 32'(enbar), 32'(en_exp));
    end
  endtask

  initial begin
    int n;
    int s;
    logic [19:0] hv;

    rst  = 1'b1;
    load = 1'b0;
    in   = 16'd0;
    tog  = 1'b0;

    // Reset
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enbar", 32'(enbar), 32'h1e);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_sel", 32'(dig_sel), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("div1_sel%0d", i), 32'(dig_sel1), 32'(i % 5));
      if (i == 3) chk("div4_sel_hold", 32'(dig_sel), 32'd0);
      if (i == 4) chk("div4_sel_step", 32'(dig_sel), 32'd1);
    end

    // Decimal 1234
    load = 1'b1; in = 16'd1234; tog = 1'b0;
    step();
    load = 1'b0;
    chk("d1234_busy_on", 32'(busy), 32'd1);
    wait_idle(n);
    chk("d1234_busy_len", 32'(n), 32'd16);
    scan_chk("d1234", 20'h01234, 5'b10000);

    // Decimal 42069, internal zero shown
    load = 1'b1; in = 16'd42069;
    step();
    load = 1'b0;
    wait_idle(n);
    chk("d42069_busy_len", 32'(n), 32'd16);
    scan_chk("d42069", 20'h42069, 5'b00000);

    // Hex 0xFAAA
    load = 1'b1; in = 16'hFAAA; tog = 1'b1;
    step();
    load = 1'b0; tog = 1'b0;
    chk("hex_busy", 32'(busy), 32'd0);
    hv = 20'h0FAAA;
    s  = int'(dig_sel);
    chk("hex_next_digit", 32'(digit), 32'(hv[4*s +: 4]));
    scan_chk("hex", 20'h0FAAA, 5'b10000);
    chk("hex_busy_after", 32'(busy), 32'd0);

    // Dropped load
    load = 1'b1; in = 16'd6969;
    step();
    load = 1'b0;
    repeat (4) step();
    load = 1'b1; in = 16'd1234;
    step();
    load = 1'b0;
    wait_idle(n);
    chk("drop_busy_rest", 32'(n), 32'd11);
    step();
    chk("drop_no_restart", 32'(busy), 32'd0);
    scan_chk("drop", 20'h06969, 5'b10000);

    // Reset mid-conversion, with a simultaneous load that must be dropped
    load = 1'b1; in = 16'd12345;
    step();
    load = 1'b0;
    repeat (7) step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1; load = 1'b1; in = 16'd999;
    step();
    rst = 1'b0; load = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sel", 32'(dig_sel), 32'd0);
    chk("mid_rst_digit", 32'(digit), 32'd0);
    chk("mid_rst_enbar", 32'(enbar), 32'h1e);
    step();
    chk("mid_rst_load_dropped", 32'(busy), 32'd0);
    scan_chk("mid_zero", 20'h00000, 5'b11110);

    load = 1'b1; in = 16'd65535;
    step();
    load = 1'b0;
    wait_idle(n);
    chk("max_busy_len", 32'(n), 32'd16);
    scan_chk("max", 20'h65535, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
